// File: rtl/instr_prefetch_if.sv
// Bus bundle for the instruction prefetch buffer: the memory read port on one
// side and the processor byte-delivery / jump port on the other.
//
// Handshake semantics:
//   memory side    - memStrobe=1 in cycle N requests the byte at memAddr;
//                    memDataRead carries that byte during cycle N+1.
//   processor side - outValid=1 means outData/outAddr hold the head entry;
//                    the head is consumed on a rising edge where outValid=1
//                    and outTake=1. outTake with outValid=0 has no effect.
//                    jumpEn=1 overrides the take and redirects fetching.
interface instr_prefetch_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memStrobe;
  logic [7:0]            memDataRead;
  logic [7:0]            outData;
  logic [ADDR_WIDTH-1:0] outAddr;
  logic                  outValid;
  logic                  outTake;
  logic                  jumpEn;
  logic [ADDR_WIDTH-1:0] jumpAddr;

  // Prefetch buffer view
  modport master (
    output memAddr, memStrobe, outData, outAddr, outValid,
    input  memDataRead, outTake, jumpEn, jumpAddr
  );

  // Memory + processor view
  modport slave (
    input  memAddr, memStrobe, outData, outAddr, outValid,
    output memDataRead, outTake, jumpEn, jumpAddr
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction-byte prefetch buffer. Issues sequential byte reads to a
// synchronous-read memory, queues returned bytes with their addresses in a
// small FIFO and hands them to the processor one per take. A jump flushes the
// queue, discards the byte in flight and restarts fetching at the target.
module instr_prefetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_prefetch_if.master     bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage (data and its fetch address)
  logic [7:0]            fifo_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];

  // Control state
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  // Derived controls
  logic [CW:0]           inflight;
  logic                  issue_ok;
  logic                  out_valid;
  logic                  do_write;
  logic                  do_take;

  // Occupancy including the read in flight; a same-cycle take is deliberately
  // not credited, so the FIFO can never be asked to hold more than DEPTH.
  assign inflight  = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
  assign issue_ok  = (inflight < (CW + 1)'(DEPTH));
  assign out_valid = (count_q != '0);

  // A jump kills the returning byte and any take in the same cycle.
  assign do_write  = pending_q & ~bus.jumpEn;
  assign do_take   = out_valid & bus.outTake & ~bus.jumpEn;

  // Memory request port; silent while reset is held.
  always_comb begin
    bus.memStrobe = 1'b0;
    bus.memAddr   = RESET_PC;
    if (!reset) begin
      if (bus.jumpEn) begin
        bus.memStrobe = 1'b1;
        bus.memAddr   = bus.jumpAddr;
      end else begin
        bus.memStrobe = issue_ok;
        bus.memAddr   = fetch_pc_q;
      end
    end
  end

  // Processor port; data and address read as zero when nothing is queued.
  always_comb begin
    bus.outValid = out_valid;
    bus.outData  = '0;
    bus.outAddr  = '0;
    if (out_valid) begin
      bus.outData = fifo_data_q[rd_ptr_q];
      bus.outAddr = fifo_addr_q[rd_ptr_q];
    end
  end

  // Next-state logic for pointers, count, in-flight read and fetch address.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pending_d   = pending_q;
    pend_addr_d = pend_addr_q;
    fetch_pc_d  = fetch_pc_q;

    if (bus.jumpEn) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pending_d   = 1'b1;
      pend_addr_d = bus.jumpAddr;
      fetch_pc_d  = bus.jumpAddr + ADDR_WIDTH'(1);
    end else begin
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_take) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d   = count_q + CW'(do_write) - CW'(do_take);
      pending_d = issue_ok;
      if (issue_ok) begin
        pend_addr_d = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      fetch_pc_q  <= RESET_PC;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      pend_addr_q <= pend_addr_d;
      fetch_pc_q  <= fetch_pc_d;
    end
  end

  // FIFO storage: capture the returning byte at the tail. No reset needed,
  // entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_write) begin
      fifo_data_q[wr_ptr_q] <= bus.memDataRead;
      fifo_addr_q[wr_ptr_q] <= pend_addr_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: driver tasks issue resets, jumps and take
// patterns and push the expected byte stream into exp_q; a monitor pops and
// compares each delivered byte and checks the memory request port every cycle.
module tb_instr_prefetch;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_prefetch_if #(.ADDR_WIDTH(8)) bus ();

  instr_prefetch #(
    .ADDR_WIDTH (8),
    .DEPTH      (4),
    .RESET_PC   (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  logic [7:0] mem_rd;

  function automatic logic [7:0] exp_byte(input logic [7:0] a);
    case (a)
      8'h00: exp_byte = 8'h0C;
      8'h01: exp_byte = 8'h0A;
      8'h02: exp_byte = 8'h1C;
      8'h03: exp_byte = 8'h14;
      8'h04: exp_byte = 8'h02;
      8'h05: exp_byte = 8'h01;
      8'h06: exp_byte = 8'hFF;
      8'h07: exp_byte = 8'h8D;
      default: exp_byte = a ^ 8'h5A;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = exp_byte(8'(i));
    mem_rd = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.memStrobe) mem_rd <= mem[bus.memAddr];
  end
  assign bus.memDataRead = mem_rd;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks;
  int n_errors;
  int n_pops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [7:0] start, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 8'(i);
      exp_q.push_back({a, exp_byte(a)});
    end
  endtask

  // ---------------- monitor ----------------
  // m_cp models (queued + in-flight) at the start of a cycle, m_pc the fetch address.
  int         m_cp;
  logic [7:0] m_pc;
  logic       m_strobe;
  logic       m_pop;
  logic [15:0] m_exp;

  initial begin
    m_cp = 0;
    m_pc = 8'h00;
  end

  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs",
            {bus.outValid, bus.memStrobe, bus.memAddr, bus.outData, bus.outAddr}, 32'h0);
      m_cp = 0;
      m_pc = 8'h00;
    end else begin
      m_strobe = bus.jumpEn | (m_cp < 4);
      check("mem_strobe", {31'h0, bus.memStrobe}, {31'h0, m_strobe});
      check("mem_addr", {24'h0, bus.memAddr}, {24'h0, bus.jumpEn ? bus.jumpAddr : m_pc});
      if (!bus.outValid) check("idle_zero", {16'h0, bus.outData, bus.outAddr}, 32'h0);
      m_pop = bus.outValid & bus.outTake & ~bus.jumpEn;
      if (m_pop) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {16'h0, bus.outAddr, bus.outData}, 32'hFFFF_FFFF);
        end else begin
          m_exp = exp_q.pop_front();
          check("stream_addr_data", {16'h0, bus.outAddr, bus.outData}, {16'h0, m_exp});
        end
      end
      if (bus.jumpEn) begin
        m_cp = 1;
        m_pc = bus.jumpAddr + 8'd1;
      end else begin
        m_cp = m_cp + (m_strobe ? 1 : 0) - (m_pop ? 1 : 0);
        if (m_strobe) m_pc = m_pc + 8'd1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [7:0] target, input logic take);
    bus.jumpEn   = 1'b1;
    bus.jumpAddr = target;
    bus.outTake  = take;
    exp_q.delete();
    n_pops = 0;
  endtask

  logic [3:0] p1_strobe;
  logic [3:0] p1_valid;

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pops   = 0;
    reset        = 1'b1;
    bus.outTake  = 1'b0;
    bus.jumpEn   = 1'b0;
    bus.jumpAddr = 8'h00;
    repeat (3) next_cycle();

    // Phase 1: reset release, no takes; four strobes 00..03 then stall.
    reset = 1'b0;
    push_stream(8'h00, 16);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      p1_strobe = (c <= 4) ? 4'd1 : 4'd0;
      p1_valid  = (c >= 3) ? 4'd1 : 4'd0;
      check("p1_strobe", {31'h0, bus.memStrobe}, {28'h0, p1_strobe});
      if (c <= 4) check("p1_addr", {24'h0, bus.memAddr}, 32'(c - 1));
      check("p1_valid", {31'h0, bus.outValid}, {28'h0, p1_valid});
      if (c >= 3) check("p1_head", {16'h0, bus.outAddr, bus.outData}, 32'h0000_000C);
      next_cycle();
    end

    // Phase 2: continuous takes; one byte per cycle, no bubbles.
    n_pops = 0;
    bus.outTake = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("p2_no_bubble", {31'h0, bus.outValid}, 32'h1);
      next_cycle();
    end
    check("p2_pop_count", n_pops, 12);

    // Phase 3: jump to 02 while streaming.
    do_jump(8'h02, 1'b1);
    push_stream(8'h02, 16);
    @(negedge clk);
    check("p3_jump_req", {23'h0, bus.memStrobe, bus.memAddr}, 32'h0000_0102);
    next_cycle();
    bus.jumpEn = 1'b0;
    @(negedge clk);
    check("p3_flushed", {31'h0, bus.outValid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("p3_target_head", {15'h0, bus.outValid, bus.outAddr, bus.outData}, 32'h0001_021C);
    next_cycle();
    repeat (4) next_cycle();
    check("p3_pop_count", n_pops, 5);

    // Phase 4: jump to FE, addresses wrap through FF to 00.
    do_jump(8'hFE, 1'b1);
    exp_q.push_back({8'hFE, 8'hA4});
    exp_q.push_back({8'hFF, 8'hA5});
    exp_q.push_back({8'h00, 8'h0C});
    exp_q.push_back({8'h01, 8'h0A});
    push_stream(8'h02, 16);
    next_cycle();
    bus.jumpEn = 1'b0;
    repeat (8) next_cycle();
    check("p4_pop_count", {31'h0, n_pops >= 4}, 32'h1);

    // Phase 5: alternating takes; stream stays in order, strobe throttled.
    do_jump(8'h00, 1'b0);
    push_stream(8'h00, 40);
    next_cycle();
    bus.jumpEn = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.outTake = (c % 2 == 0);
      next_cycle();
    end
    check("p5_pop_count", {31'h0, n_pops >= 15}, 32'h1);

    // Phase 6a: reset mid-stream with a read in flight.
    bus.outTake = 1'b1;
    repeat (6) next_cycle();
    reset = 1'b1;
    exp_q.delete();
    push_stream(8'h00, 16);
    #1;
    check("p6_reset_immediate", {30'h0, bus.outValid, bus.memStrobe}, 32'h0);
    repeat (2) next_cycle();
    reset = 1'b0;
    n_pops = 0;
    repeat (6) next_cycle();
    check("p6_restart_pops", {31'h0, n_pops >= 1}, 32'h1);

    // Phase 6b: jump and take in the same cycle; take ignored, flush as before.
    @(negedge clk);
    check("p6_valid_before_jump", {31'h0, bus.outValid}, 32'h1);
    next_cycle();
    do_jump(8'h02, 1'b1);
    push_stream(8'h02, 16);
    next_cycle();
    bus.jumpEn = 1'b0;
    @(negedge clk);
    check("p6_flushed", {31'h0, bus.outValid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("p6_target_head", {15'h0, bus.outValid, bus.outAddr, bus.outData}, 32'h0001_021C);
    repeat (4) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
